// File: rtl/alu_vector_sequencer_if.sv
// alu_vector_sequencer_if: control, ALU drive/return and result bus of the vector sequencer
interface alu_vector_sequencer_if;
    logic        start;
    logic        abort;
    logic        step_mode;
    logic        step;
    logic [31:0] alu_f;
    logic        alu_zf;
    logic        alu_of;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  idx;
    logic        busy;
    logic        done;
    logic [31:0] last_f;
    logic [6:0]  zf_cnt;
    logic [6:0]  of_cnt;
    logic [31:0] signature;
    modport master (
        output start, abort, step_mode, step, alu_f, alu_zf, alu_of,
        input  alu_op, alu_a, alu_b, idx, busy, done, last_f, zf_cnt, of_cnt, signature
    );
    modport slave (
        input  start, abort, step_mode, step, alu_f, alu_zf, alu_of,
        output alu_op, alu_a, alu_b, idx, busy, done, last_f, zf_cnt, of_cnt, signature
    );
endinterface

// File: rtl/alu_vector_sequencer.sv
// alu_vector_sequencer: walks 8 operand pairs x 8 opcodes into an external ALU,
// capturing F/ZF/OF into flag counts and a rotate-xor signature.
module alu_vector_sequencer #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] SIG_SEED      = 32'hFFFF_FFFF
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_vector_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, CAPTURE, PAUSE, DONE} state_t;
    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);
    state_t      r_state;
    logic [5:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [31:0] r_last_f;
    logic [6:0]  r_zf_cnt;
    logic [6:0]  r_of_cnt;
    logic [31:0] r_sig;
    logic        r_busy;
    logic        r_done;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_go;
    logic        w_abort;
    // abort outranks start, so a simultaneous pair leaves the sequencer idle
    assign w_go    = bus.start && !bus.abort && (r_state == IDLE || r_state == DONE);
    assign w_abort = bus.abort && r_busy;
    always_comb begin
        w_a = 32'h0000_0000;
        w_b = 32'hFFFF_FFFF;
        case (r_idx[5:3])
            3'd1:    begin w_a = 32'h0000_0003; w_b = 32'h0000_0607; end
            3'd2:    begin w_a = 32'h8000_0000; w_b = 32'h8000_0000; end
            3'd3:    begin w_a = 32'h7FFF_FFFF; w_b = 32'h7FFF_FFFF; end
            3'd4:    begin w_a = 32'hFFFF_FFFF; w_b = 32'hFFFF_FFFF; end
            3'd5:    begin w_a = 32'h8000_0000; w_b = 32'hFFFF_FFFF; end
            3'd6:    begin w_a = 32'hFFFF_FFFF; w_b = 32'h8000_0000; end
            3'd7:    begin w_a = 32'h1234_5678; w_b = 32'h3333_2222; end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_last_f <= '0;
            r_zf_cnt <= '0;
            r_of_cnt <= '0;
            r_sig    <= SIG_SEED;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_go) begin
            r_state  <= DRIVE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_last_f <= '0;
            r_zf_cnt <= '0;
            r_of_cnt <= '0;
            r_sig    <= SIG_SEED;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                DRIVE: begin
                    r_cnt   <= (r_cnt == LAST_CNT) ? 4'd0 : r_cnt + 4'd1;
                    r_state <= (r_cnt == LAST_CNT) ? CAPTURE : DRIVE;
                end
                CAPTURE: begin
                    r_last_f <= bus.alu_f;
                    r_zf_cnt <= r_zf_cnt + 7'(bus.alu_zf);
                    r_of_cnt <= r_of_cnt + 7'(bus.alu_of);
                    r_sig    <= {r_sig[30:0], r_sig[31]} ^ bus.alu_f;
                    if (r_idx == 6'd63) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 6'd1;
                        r_state <= bus.step_mode ? PAUSE : DRIVE;
                    end
                end
                PAUSE:   r_state <= bus.step ? DRIVE : PAUSE;
                default: ;
            endcase
        end
    end
    assign bus.alu_op    = r_idx[2:0];
    assign bus.alu_a     = w_a;
    assign bus.alu_b     = w_b;
    assign bus.idx       = r_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.last_f    = r_last_f;
    assign bus.zf_cnt    = r_zf_cnt;
    assign bus.of_cnt    = r_of_cnt;
    assign bus.signature = r_sig;
endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
- Initiator-side counterpart to the lab's combinational multi-function ALU.
- Replaces the manual switch settings with a clocked sequencer. It walks all 8 operand pairs × 8 opcodes (64 vectors) and drives ALU_OP/A/B to an external ALU.
- After a settle time it captures F/ZF/OF and accumulates a flag count and a 32-bit signature for board or bench checking.
- Supports free-run and single-step modes.

Parameters:
- SETTLE_CYCLES, 2, cycles operands are held before capture; legal range 1..15.
- SIG_SEED, 32'hFFFFFFFF, signature value loaded on reset and on start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a 64-vector run.
- abort  in  1  one-cycle pulse; stops the run and returns to IDLE.
- step_mode  in  1  1 = pause after each capture.
- step  in  1  one-cycle pulse; advances from pause.
- alu_f  in  32  ALU result.
- alu_zf  in  1  ALU zero flag.
- alu_of  in  1  ALU overflow flag.
- alu_op  out  3  opcode to ALU; equals idx[2:0].
- alu_a  out  32  operand A, decoded from idx[5:3].
- alu_b  out  32  operand B, decoded from idx[5:3].
- idx  out  6  current vector index {pair, op}.
- busy  out  1  high in DRIVE, CAPTURE and PAUSE.
- done  out  1  high in DONE.
- last_f  out  32  most recently captured alu_f.
- zf_cnt  out  7  number of captures with alu_zf=1.
- of_cnt  out  7  number of captures with alu_of=1.
- signature  out  32  running result signature.

Behaviour:
- Operand table (pair: A, B):
  - 0: 00000000, FFFFFFFF
  - 1: 00000003, 00000607
  - 2: 80000000, 80000000
  - 3: 7FFFFFFF, 7FFFFFFF
  - 4: FFFFFFFF, FFFFFFFF
  - 5: 80000000, FFFFFFFF
  - 6: FFFFFFFF, 80000000
  - 7: 12345678, 33332222
- alu_a, alu_b, alu_op are combinational decodes of the registered idx. They are stable for the whole DRIVE period.
- Reset (async, rst_n=0) sets:
  - state=IDLE, idx=0, settle counter=0
  - last_f=0, zf_cnt=0, of_cnt=0, signature=SIG_SEED
  - busy=0, done=0
  - hence alu_op=0, alu_a=00000000, alu_b=FFFFFFFF
- States:
  - IDLE: start → clear idx, counters and last_f; signature=SIG_SEED; go to DRIVE.
  - DRIVE: settle counter counts SETTLE_CYCLES cycles, then go to CAPTURE.
  - CAPTURE: single cycle.
    - last_f ← alu_f.
    - zf_cnt += alu_zf; of_cnt += alu_of.
    - signature ← {signature[30:0], signature[31]} ^ alu_f.
    - If idx==63 → DONE, idx holds at 63.
    - Otherwise idx increments (op is the fastest-changing field). Next state is PAUSE if step_mode=1, else DRIVE.
  - PAUSE: waits indefinitely; step → DRIVE.
  - DONE: holds all results; start → same restart as from IDLE.
- Timing (run mode):
  - start sampled at edge k → DRIVE during cycles k+1..k+S, where S=SETTLE_CYCLES.
  - First capture at edge k+S+1.
  - Each vector takes S+1 cycles; done rises at edge k+64·(S+1).
- Edge cases:
  - start while busy is ignored.
  - step outside PAUSE is ignored.
  - abort in any busy state → IDLE next edge. idx and stats hold their values; done=0.
  - abort and start in the same cycle: abort wins.
  - Counters cannot wrap, since the maximum is 64 and the width is 7 bits.
  - step_mode is sampled only in CAPTURE.
  - Reset asserted mid-run forces the reset values immediately, regardless of the clock.

Test Plan:
1. Stub ALU (alu_f=0, zf=1, of=0), S=2, start pulse → done 192 cycles after start. Final values: zf_cnt=64, of_cnt=0, signature=FFFFFFFF, idx=63.
2. Behavioural ALU model, run mode, inspect individual captures:
   - idx=0x04: alu_a=0, alu_b=FFFFFFFF, op ADD → last_f=FFFFFFFF, zf=0, of=0.
   - idx=0x14: 80000000+80000000 → last_f=0, zf=1, of=1.
   - idx=0x1C: 7FFFFFFF+7FFFFFFF → last_f=FFFFFFFE, of=1.
   - Final signature must match the bench model.
3. step_mode=1: after the first capture, idx=1 and busy=1, and idx holds for 20 cycles. A step pulse resumes; the next capture follows exactly S+1 cycles later.
4. abort at idx=10 → IDLE: busy=0, done=0, idx=10, counts held. Then a start pulse → idx=0, counts=0, signature=SIG_SEED.
5. rst_n low at idx=30 mid-DRIVE, asynchronous to clk → all outputs at reset values in the same cycle. Deassert, then start → a full run is produced correctly.
6. start pulse during busy, plus a step pulse in run mode → no effect on idx or timing.
